// File: rtl/stack_calc_pkg.sv
// Shared constants for the 4-bit stack calculator: stack size, stack modes,
// opcodes, FSM states and operand-count helpers.
package stack_calc_pkg;

    localparam int STACK_SIZE = 8;

    localparam logic [2:0] MODE_HOLD    = 3'd0;
    localparam logic [2:0] MODE_PUSH    = 3'd1;
    localparam logic [2:0] MODE_POP     = 3'd2;
    localparam logic [2:0] MODE_REPLACE = 3'd3;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_POP  = 4'd2;
    localparam logic [3:0] OP_DUP  = 4'd3;
    localparam logic [3:0] OP_SWAP = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_S3
    } state_t;

    // Minimum number of live stack entries an opcode consumes.
    function automatic logic [1:0] operand_count(input logic [3:0] op);
        logic [1:0] n;
        case (op)
            OP_POP, OP_DUP, OP_NOT:                      n = 2'd1;
            OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR:                                      n = 2'd2;
            default:                                     n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic is_binary(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational 4-bit ALU; a is the stack top, b the second entry, and
// SUB computes b - a with carry_out flagging the borrow.
module stack_alu
    import stack_calc_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] result,
    output logic       carry_out
);

    logic [4:0] w_sum;

    assign w_sum = {1'b0, b} + {1'b0, a};

    always_comb begin
        result    = 4'd0;
        carry_out = 1'b0;
        case (op)
            OP_ADD: begin
                result    = w_sum[3:0];
                carry_out = w_sum[4];
            end
            OP_SUB: begin
                result    = b - a;
                carry_out = (b < a);
            end
            OP_AND:  result = b & a;
            OP_OR:   result = b | a;
            OP_XOR:  result = b ^ a;
            default: result = 4'd0;
        endcase
    end

endmodule

// File: rtl/stack_register.sv
// Downstream 4-bit LIFO register file driven by mode/in_word; contents are
// deliberately left unreset because the controller tracks logical depth.
module stack_register
    import stack_calc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic [2:0] mode,
    input  logic [3:0] in_word,
    output logic [3:0] top_word,
    output logic [3:0] second_word
);

    logic [3:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        case (mode)
            MODE_PUSH: begin
                r_mem[0] <= in_word;
                for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
            end
            MODE_POP: begin
                for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
                r_mem[DEPTH-1] <= 4'd0;
            end
            MODE_REPLACE: r_mem[0] <= in_word;
            default: ;
        endcase
    end

    assign top_word    = r_mem[0];
    assign second_word = r_mem[1];

endmodule

// File: rtl/stack_calc_controller.sv
// Command sequencer for the stack calculator: turns one opcode into a short
// run of stack modes, tracks logical depth and flags rejected commands.
module stack_calc_controller #(
    parameter int STACK_SIZE = stack_calc_pkg::STACK_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       cmd_ready,
    input  logic [3:0] top_word,
    input  logic [3:0] second_word,
    output logic [2:0] mode,
    output logic [3:0] in_word,
    output logic       busy,
    output logic [3:0] depth,
    output logic       carry,
    output logic       err
);
    import stack_calc_pkg::*;

    localparam logic [3:0] FULL_DEPTH = 4'(STACK_SIZE);

    state_t     r_state;
    logic [3:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [2:0] r_mode;
    logic [3:0] r_in_word;
    logic [3:0] r_depth;
    logic       r_carry;
    logic       r_err;

    logic       w_busy;
    logic       w_grows;
    logic       w_reject;
    logic [3:0] w_alu_result;
    logic       w_alu_carry;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_grows  = (cmd_op == OP_PUSH) || (cmd_op == OP_DUP);
    // Underflow and overflow are both decided from the depth at acceptance.
    assign w_reject = ({2'b00, operand_count(cmd_op)} > r_depth) ||
                      (w_grows && (r_depth >= FULL_DEPTH));

    stack_alu u_alu (
        .op        (r_op),
        .a         (r_a),
        .b         (r_b),
        .result    (w_alu_result),
        .carry_out (w_alu_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_NOP;
            r_a       <= 4'd0;
            r_b       <= 4'd0;
            r_mode    <= MODE_HOLD;
            r_in_word <= 4'd0;
            r_depth   <= 4'd0;
            r_carry   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mode    <= MODE_HOLD;
                    r_in_word <= 4'd0;
                    if (cmd_valid) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_op <= cmd_op;
                            r_a  <= top_word;
                            r_b  <= second_word;
                            case (cmd_op)
                                OP_PUSH: begin
                                    r_state   <= ST_S1;
                                    r_mode    <= MODE_PUSH;
                                    r_in_word <= cmd_data;
                                    r_depth   <= r_depth + 4'd1;
                                end
                                OP_DUP: begin
                                    r_state   <= ST_S1;
                                    r_mode    <= MODE_PUSH;
                                    r_in_word <= top_word;
                                    r_depth   <= r_depth + 4'd1;
                                end
                                OP_POP: begin
                                    r_state <= ST_S1;
                                    r_mode  <= MODE_POP;
                                    r_depth <= r_depth - 4'd1;
                                end
                                OP_NOT: begin
                                    r_state   <= ST_S1;
                                    r_mode    <= MODE_REPLACE;
                                    r_in_word <= ~top_word;
                                end
                                OP_SWAP: begin
                                    r_state <= ST_S1;
                                    r_mode  <= MODE_POP;
                                end
                                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                                    r_state <= ST_S1;
                                    r_mode  <= MODE_POP;
                                    r_depth <= r_depth - 4'd1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_S1: begin
                    if (is_binary(r_op)) begin
                        r_state   <= ST_S2;
                        r_mode    <= MODE_REPLACE;
                        r_in_word <= w_alu_result;
                        if ((r_op == OP_ADD) || (r_op == OP_SUB)) r_carry <= w_alu_carry;
                    end else if (r_op == OP_SWAP) begin
                        r_state   <= ST_S2;
                        r_mode    <= MODE_REPLACE;
                        r_in_word <= r_a;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_mode    <= MODE_HOLD;
                        r_in_word <= 4'd0;
                    end
                end
                ST_S2: begin
                    // SWAP finishes by pushing the old second entry back on top.
                    if (r_op == OP_SWAP) begin
                        r_state   <= ST_S3;
                        r_mode    <= MODE_PUSH;
                        r_in_word <= r_b;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_mode    <= MODE_HOLD;
                        r_in_word <= 4'd0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mode    <= MODE_HOLD;
                    r_in_word <= 4'd0;
                end
            endcase
        end
    end

    assign busy      = w_busy;
    assign cmd_ready = !w_busy;
    assign mode      = r_mode;
    assign in_word   = r_in_word;
    assign depth     = r_depth;
    assign carry     = r_carry;
    assign err       = r_err;

endmodule

// File: doc/stack_calc_controller.md
# stack_calc_controller

Command sequencer for the 4-bit stack calculator. It accepts one opcode at a time, decodes it into a sequence of stack-mode cycles, and drives the `mode`/`in_word` inputs of the 8-deep `stack_register` directly downstream. It reads back that block's `top_word`/`second_word` to compute ALU results and write them onto the stack. It also tracks logical stack depth, so underflow and overflow are rejected instead of silently corrupting the stack.

## Interface
Parameters:
- `STACK_SIZE`, 8: logical stack depth; must match the downstream stack.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  4  opcode.
- `cmd_data`  in  4  literal operand for PUSH.
- `cmd_ready`  out  1  equals `!busy`; a command is accepted when `cmd_valid && cmd_ready`.
- `top_word`  in  4  current stack top, from the stack.
- `second_word`  in  4  current second entry, from the stack.
- `mode`  out  3  stack mode, registered.
- `in_word`  out  4  word shifted or written into the stack, registered.
- `busy`  out  1  a command sequence is in flight.
- `depth`  out  4  logical entries, 0..8.
- `carry`  out  1  carry/borrow of the last ADD/SUB.
- `err`  out  1  sticky error; set when a command is rejected, cleared only by `rst`.

## Operation
- Mode encodings: HOLD=0, PUSH=1 (shift down, `in_word` to top), POP=2 (shift up), REPLACE=3 (overwrite top only).
- Opcodes:
  - NOP=0
  - PUSH=1
  - POP=2
  - DUP=3
  - SWAP=4
  - ADD=5
  - SUB=6 (second − top)
  - AND=7
  - OR=8
  - XOR=9
  - NOT=10 (unary)
  - 11–15: reserved, treated as NOP.
- At acceptance, latch `a=top_word`, `b=second_word`.
- States: IDLE, S1, S2. All states outside IDLE assert `busy`.
  - PUSH: IDLE→S1 with `mode=PUSH`, `in_word=cmd_data`; then back to IDLE.
  - DUP: same as PUSH with `in_word=a`.
  - POP: S1 with `mode=POP`.
  - NOT: S1 with `mode=REPLACE`, `in_word=~a`.
  - Binary ops (ADD, SUB, AND, OR, XOR): S1 with `mode=POP`, then S2 with `mode=REPLACE`, `in_word=alu(b,a)`.
  - SWAP: S1 with `mode=POP`, then S2 with `mode=REPLACE`, `in_word=a`, then S3 with `mode=PUSH`, `in_word=b`. SWAP uses a third state S3.
- In every state without a listed mode, the outputs are `mode=HOLD`, `in_word=0`.
- Arithmetic wraps at 4 bits.
  - ADD: `carry` = bit 4 of a+b.
  - SUB: `carry` = 1 when b<a (borrow).
  - `carry` is unchanged by all other ops.
- Depth update, applied at acceptance:
  - +1: PUSH, DUP.
  - −1: POP and binary ops.
  - 0: SWAP, NOT, NOP.
- Rejection rules:
  - PUSH or DUP at depth==8 → reject.
  - POP, NOT or DUP at depth==0 → reject.
  - Binary ops or SWAP at depth<2 → reject.
  - A rejected command is consumed: it takes one IDLE cycle, leaves `mode=HOLD` and `depth` unchanged, and sets `err`.
- Reset values: state IDLE, `mode=HOLD`, `in_word=0`, `busy=0`, `depth=0`, `carry=0`, `err=0`. Stack contents are unspecified after reset but logically empty.
- Reset mid-sequence: the next cycle drives HOLD. Any partially applied stack change stays as-is and is not tracked.

## Timing
- Accept at edge N. `mode`/`in_word` are valid for the cycle after N, and the stack updates at edge N+1.
- Command lengths:
  - PUSH, POP, DUP, NOT: 1 busy cycle. `cmd_ready` returns after edge N+1, so the next accept is at edge N+2 at the earliest.
  - Binary ops: 2 busy cycles.
  - SWAP: 3 busy cycles.
  - NOP and rejected commands: 0 busy cycles, so back-to-back accepts are allowed.
- `busy` and `depth` are registered and update at edge N.
- `cmd_valid` while busy is ignored; there is no queuing.
- `a`/`b` are sampled only in IDLE, when the stack is stable because `mode` is HOLD.

## Structure
- `stack_calc_pkg` holds: `STACK_SIZE`; the mode constants; the opcode constants; and the operand-count lookup used for underflow checks.
- Sub-module `stack_alu` (combinational): inputs `op`, `a`, `b`; outputs `result[3:0]`, `carry_out`.
- The FSM, depth counter and error flag live in `stack_calc_controller`.
- The bench instantiates the controller together with `stack_register`.

## Test plan
- Reset, then PUSH 3, PUSH 5, ADD → `top_word`=8, `depth`=1, `carry`=0; ADD holds `busy` high for 2 cycles.
- PUSH 2, PUSH 7, SUB → top=11 (2−7 wrapped), `carry`=1. Then PUSH 9, PUSH 9, ADD → top=2, `carry`=1.
- PUSH 1, PUSH 4, SWAP → top=1, second=4, `depth`=2, `busy` high for exactly 3 cycles.
- PUSH 15 nine times → the 9th is rejected: `err`=1, `depth`=8, `mode` stays HOLD. POP from depth 0 after reset → `err`=1, `depth`=0.
- Hold `cmd_valid` high continuously with alternating PUSH/POP → each command is accepted exactly once. Commands presented while busy are ignored.
- Assert `rst` during S1 of an ADD → next cycle `mode`=HOLD; `depth`, `busy`, `err` and `carry` are all 0; the following PUSH 6 gives top=6, `depth`=1.
